uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver in the I/O subsystem.
- Configurable data width, parity mode and stop-bit count.
- Synchronises the asynchronous rx line and validates the start bit at mid-bit.
- Reports parity and framing errors alongside a one-cycle done strobe.
- Sits between the board RX pin and the processor I/O register / RX buffer.

Parameters:
CLOCKS_PER_BIT, 50, clk cycles per bit period (>= 4).
DATA_BITS, 8, data bits per frame, legal 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame, 1 or 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
rx_in  input  1  asynchronous serial line, idle high.
rx_byte  output  DATA_BITS  last received data word, LSB = first bit on wire.
rx_done  output  1  one-cycle pulse: frame complete, outputs updated.
parity_err  output  1  parity mismatch in the frame flagged by rx_done.
frame_err  output  1  a stop bit sampled low in the frame flagged by rx_done.
busy  output  1  high while a frame is in progress (any state except IDLE).

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- rx_in passes through a 2-flop synchroniser, which resets to 1. All sampling uses the synchronised value rxs.
- Reset, including mid-frame: state = IDLE, all counters 0, rx_byte = 0, rx_done = 0, parity_err = 0, frame_err = 0, busy = 0, synchroniser = 1. Effective from the next cycle.
- States: IDLE, START, DATA, PARITY, STOP, DONE, WAIT_HIGH.
- IDLE: on rxs = 0, go to START with clock_count = 0.
- START:
  - Count to CLOCKS_PER_BIT/2 - 1, then sample rxs.
  - rxs = 1: false start. Return to IDLE, no rx_done, outputs unchanged.
  - rxs = 0: go to DATA with counter cleared.
- DATA:
  - Each bit is sampled when the counter reaches CLOCKS_PER_BIT - 1, i.e. at mid-bit.
  - Bits shift into a staging register, LSB first.
  - After DATA_BITS samples: go to PARITY if PARITY != 0, else STOP.
- PARITY:
  - Sample one bit and compare with the XOR of the staging data.
  - Odd mode: XOR(data, parity bit) must be 1. Even mode: it must be 0.
  - Mismatch sets an internal parity flag.
- STOP:
  - Sample STOP_BITS bits, one CLOCKS_PER_BIT apart.
  - Any sample = 0 sets an internal frame flag.
  - The state is left immediately at the mid-point of the last stop bit, which allows back-to-back frames.
- DONE (one cycle):
  - rx_done = 1.
  - rx_byte <= staging; parity_err and frame_err <= internal flags.
  - Next state: IDLE if rxs = 1, otherwise WAIT_HIGH. This covers break or framing errors and prevents re-triggering on a held-low line.
- WAIT_HIGH: stay until rxs = 1, then go to IDLE. busy = 1.
- rx_byte, parity_err and frame_err hold their values until the next rx_done. rx_done is never high for two consecutive cycles.
- Timing, with t0 = first cycle rxs = 0 in IDLE and CPB = CLOCKS_PER_BIT:
  - Start sample: t0 + CPB/2.
  - Data bit i: t0 + CPB/2 + (i+1)·CPB.
  - Parity and stop bits follow at CPB spacing.
  - rx_done: cycle after the last stop sample.
  - Pin-to-rxs latency: 2 cycles.
- clock_count width is sized for CLOCKS_PER_BIT; no wrap-around occurs within a bit period.

Test Plan:
- 8N1, CLOCKS_PER_BIT = 16: send 0xA5 -> single rx_done pulse, rx_byte = 0xA5, parity_err = 0, frame_err = 0, busy low after DONE.
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_done pulses, rx_byte = 0x00 then 0xFF, no missed start.
- PARITY = 2, DATA_BITS = 7: send 0x41 with a correct parity bit -> parity_err = 0; resend with parity bit flipped -> rx_byte = 0x41, parity_err = 1.
- STOP_BITS = 2: second stop bit driven low -> frame_err = 1. Line then held low 5 bit periods (break) -> no further rx_done until the line returns high and a new frame is sent.
- Glitch: rx_in low for 3 cycles (< CLOCKS_PER_BIT/2), then high -> no rx_done, outputs unchanged, busy back to 0.
- Reset asserted for 1 cycle during data bit 3 of a frame -> next cycle all outputs 0, state IDLE. The next full frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable data width, parity mode and stop-bit count.
// Mid-bit sampling of a 2-flop synchronised line with parity and framing error reporting.
module uart_rx_cfg #(
  parameter int unsigned CLOCKS_PER_BIT = 50,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned PARITY         = 0,
  parameter int unsigned STOP_BITS      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(CLOCKS_PER_BIT);
  localparam int unsigned BitW = $clog2(DATA_BITS + 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(CLOCKS_PER_BIT - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StDone,
    StWaitHigh
  } state_e;

  state_e                 r_state;
  logic                   r_sync_meta;
  logic                   r_rxs;
  logic [CntW-1:0]        r_clk_cnt;
  logic [BitW-1:0]        r_bit_cnt;
  logic                   r_stop_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_flag;
  logic                   r_frame_flag;
  logic [DATA_BITS-1:0]   r_rx_byte;
  logic                   r_rx_done;
  logic                   r_parity_err;
  logic                   r_frame_err;
  logic                   r_busy;

  logic w_tick_half;
  logic w_tick_full;
  logic w_par_xor;
  logic w_par_bad;
  logic w_last_stop;
  logic w_frame_final;

  assign w_tick_half   = (r_clk_cnt == CntHalf);
  assign w_tick_full   = (r_clk_cnt == CntFull);
  // Odd mode needs an odd count of ones across data plus parity bit, even mode an even count.
  assign w_par_xor     = (^r_shift) ^ r_rxs;
  assign w_par_bad     = (PARITY == 1) ? ~w_par_xor : w_par_xor;
  assign w_last_stop   = (STOP_BITS == 1) || r_stop_cnt;
  assign w_frame_final = r_frame_flag | ~r_rxs;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_meta <= 1'b1;
      r_rxs       <= 1'b1;
    end else begin
      r_sync_meta <= rx_in;
      r_rxs       <= r_sync_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_clk_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_stop_cnt   <= 1'b0;
      r_shift      <= '0;
      r_par_flag   <= 1'b0;
      r_frame_flag <= 1'b0;
      r_rx_byte    <= '0;
      r_rx_done    <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_rx_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_clk_cnt <= '0;
          if (!r_rxs) begin
            r_state <= StStart;
            r_busy  <= 1'b1;
          end
        end
        StStart: begin
          if (w_tick_half) begin
            r_clk_cnt <= '0;
            if (r_rxs) begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end else begin
              r_state      <= StData;
              r_bit_cnt    <= '0;
              r_par_flag   <= 1'b0;
              r_frame_flag <= 1'b0;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        StData: begin
          if (w_tick_full) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rxs, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == BitLast) begin
              r_state    <= (PARITY != 0) ? StParity : StStop;
              r_stop_cnt <= 1'b0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        StParity: begin
          if (w_tick_full) begin
            r_clk_cnt  <= '0;
            r_par_flag <= w_par_bad;
            r_state    <= StStop;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        StStop: begin
          if (w_tick_full) begin
            r_clk_cnt <= '0;
            // Leave at the mid-point of the last stop bit so a following start edge is not missed.
            if (w_last_stop) begin
              r_state      <= StDone;
              r_rx_done    <= 1'b1;
              r_rx_byte    <= r_shift;
              r_parity_err <= r_par_flag;
              r_frame_err  <= w_frame_final;
            end else begin
              r_frame_flag <= w_frame_final;
              r_stop_cnt   <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        StDone: begin
          if (r_rxs) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else begin
            r_state <= StWaitHigh;
          end
        end
        StWaitHigh: begin
          if (r_rxs) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_byte    = r_rx_byte;
  assign rx_done    = r_rx_done;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8N1 receiver and a 7E2 receiver on separate lines.
module tb_uart_rx_cfg;

  localparam int unsigned Cpb = 16;

  logic       clk;
  logic       reset;
  logic       rx_a;
  logic       rx_b;
  logic [7:0] byte_a;
  logic [6:0] byte_b;
  logic       done_a, done_b;
  logic       perr_a, perr_b;
  logic       ferr_a, ferr_b;
  logic       busy_a, busy_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_a    = 0;
  int cnt_b    = 0;
  int dbl      = 0;
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  uart_rx_cfg #(
    .CLOCKS_PER_BIT(Cpb),
    .DATA_BITS     (8),
    .PARITY        (0),
    .STOP_BITS     (1)
  ) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (rx_a),
    .rx_byte   (byte_a),
    .rx_done   (done_a),
    .parity_err(perr_a),
    .frame_err (ferr_a),
    .busy      (busy_a)
  );

  uart_rx_cfg #(
    .CLOCKS_PER_BIT(Cpb),
    .DATA_BITS     (7),
    .PARITY        (2),
    .STOP_BITS     (2)
  ) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (rx_b),
    .rx_byte   (byte_b),
    .rx_done   (done_b),
    .parity_err(perr_b),
    .frame_err (ferr_b),
    .busy      (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses and flag any pulse wider than one cycle.
  always @(negedge clk) begin
    if (done_a) cnt_a++;
    if (done_b) cnt_b++;
    if ((done_a && prev_a) || (done_b && prev_b)) dbl++;
    prev_a = done_a;
    prev_b = done_b;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_rx(input int sel, input logic val);
    if (sel == 0) rx_a = val;
    else rx_b = val;
  endtask

  // Drive n bits LSB first, one bit period each; returns 1 time unit after a rising edge.
  task automatic drive_bits(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_rx(sel, bits[i]);
      repeat (Cpb) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_a(input logic [7:0] d);
    drive_bits(0, {6'b0, 1'b1, d, 1'b0}, 10);
  endtask

  task automatic send_b(input logic [6:0] d, input logic par, input logic s1, input logic s2);
    drive_bits(1, {5'b0, s2, s1, par, d, 1'b0}, 11);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    reset = 1'b1;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    idle_cycles(3);
    reset = 1'b0;
    idle_cycles(1);
    check_eq("rst_byte_a", byte_a, 0);
    check_eq("rst_flags_a", {done_a, perr_a, ferr_a, busy_a}, 0);
    check_eq("rst_byte_b", byte_b, 0);
    check_eq("rst_flags_b", {done_b, perr_b, ferr_b, busy_b}, 0);

    // 8N1 single frame
    send_a(8'hA5);
    check_eq("a5_count", cnt_a, 1);
    check_eq("a5_byte", byte_a, 8'hA5);
    check_eq("a5_errs", {perr_a, ferr_a}, 0);
    check_eq("a5_busy", busy_a, 0);

    // Back-to-back frames with no idle gap
    send_a(8'h00);
    check_eq("b2b0_count", cnt_a, 2);
    check_eq("b2b0_byte", byte_a, 8'h00);
    send_a(8'hFF);
    check_eq("b2b1_count", cnt_a, 3);
    check_eq("b2b1_byte", byte_a, 8'hFF);
    check_eq("b2b1_errs", {perr_a, ferr_a}, 0);

    // Glitch shorter than half a bit: false start
    set_rx(0, 1'b0);
    idle_cycles(3);
    set_rx(0, 1'b1);
    idle_cycles(2 * Cpb);
    check_eq("glitch_count", cnt_a, 3);
    check_eq("glitch_byte", byte_a, 8'hFF);
    check_eq("glitch_busy", busy_a, 0);

    // Asymmetric pattern pins down LSB-first ordering
    send_a(8'h1D);
    check_eq("1d_byte", byte_a, 8'h1D);
    check_eq("1d_count", cnt_a, 4);

    // 7E2: 0x41 has two ones, so even parity bit is 0
    send_b(7'h41, 1'b0, 1'b1, 1'b1);
    check_eq("par_ok_count", cnt_b, 1);
    check_eq("par_ok_byte", byte_b, 7'h41);
    check_eq("par_ok_errs", {perr_b, ferr_b}, 0);
    send_b(7'h41, 1'b1, 1'b1, 1'b1);
    check_eq("par_bad_count", cnt_b, 2);
    check_eq("par_bad_byte", byte_b, 7'h41);
    check_eq("par_bad_perr", perr_b, 1);
    check_eq("par_bad_ferr", ferr_b, 0);

    // Second stop bit low, then a 5-bit break
    send_b(7'h41, 1'b0, 1'b1, 1'b0);
    check_eq("stop2_count", cnt_b, 3);
    check_eq("stop2_errs", {perr_b, ferr_b}, 2'b01);
    idle_cycles(5 * Cpb);
    check_eq("break_count", cnt_b, 3);
    check_eq("break_busy", busy_b, 1);
    set_rx(1, 1'b1);
    idle_cycles(Cpb);
    check_eq("break_end_busy", busy_b, 0);
    // 0x12 has two ones -> even parity bit 0
    send_b(7'h12, 1'b0, 1'b1, 1'b1);
    check_eq("after_break_count", cnt_b, 4);
    check_eq("after_break_byte", byte_b, 7'h12);
    check_eq("after_break_errs", {perr_b, ferr_b}, 0);

    // Reset during data bit 3 of 0x5A
    base = cnt_a;
    drive_bits(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 4);
    set_rx(0, 1'b1);
    idle_cycles(Cpb / 2);
    reset = 1'b1;
    idle_cycles(1);
    reset = 1'b0;
    check_eq("midrst_byte_a", byte_a, 0);
    check_eq("midrst_flags_a", {done_a, perr_a, ferr_a, busy_a}, 0);
    check_eq("midrst_byte_b", byte_b, 0);
    idle_cycles(2 * Cpb);
    check_eq("midrst_no_done", cnt_a, base);
    send_a(8'h3C);
    check_eq("post_rst_count", cnt_a, base + 1);
    check_eq("post_rst_byte", byte_a, 8'h3C);
    check_eq("post_rst_errs", {perr_a, ferr_a, busy_a}, 0);

    check_eq("no_double_done", dbl, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
